// File: rtl/ysyx_23060061_axi_lite_master.sv
// ysyx_23060061_axi_lite_master
//
// Bridges a simple valid/ready core request port onto an AXI-Lite master
// interface. Only one transaction is in flight at a time. Each response carries
// the slave's resp code and the number of cycles between request acceptance and
// response.
//
// Ports
//   clk, rst (async, active-low)
//   core request : req_valid, req_ready, req_wen, req_addr, req_wdata, req_wstrb
//   core response: resp_valid, resp_ready, resp_rdata, resp_code, resp_lat
//   AXI-Lite AR/R: araddr, arvalid, arready, rdata, rresp, rvalid, rready
//   AXI-Lite AW/W/B: awaddr, awvalid, awready, wdata, wstrb, wvalid, wready,
//                    bresp, bvalid, bready
module ysyx_23060061_axi_lite_master #(
    parameter int LAT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    // core request
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wen,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [3:0]       req_wstrb,
    // core response
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic [1:0]       resp_code,
    output logic [LAT_W-1:0] resp_lat,
    // AXI-Lite read
    output logic [31:0]      araddr,
    output logic             arvalid,
    input  logic             arready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rvalid,
    output logic             rready,
    // AXI-Lite write
    output logic [31:0]      awaddr,
    output logic             awvalid,
    input  logic             awready,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    output logic             wvalid,
    input  logic             wready,
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [1:0]       rsp_code_q, rsp_code_d;
    logic [LAT_W-1:0] rsp_lat_q, rsp_lat_d;

    logic accept, ar_hs, r_hs, aw_hs, w_hs, b_hs, resp_hs;
    logic aw_all, w_all;

    function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept  = req_valid && req_ready;
    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign b_hs    = bvalid && bready;
    assign resp_hs = resp_valid && resp_ready;
    // A channel counts as complete if it finished earlier or finishes now.
    assign aw_all  = aw_done_q || aw_hs;
    assign w_all   = w_done_q || w_hs;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = req_wen ? S_WR_REQ : S_RD_ADDR;
            S_RD_ADDR: if (ar_hs) state_d = S_RD_DATA;
            S_RD_DATA: if (r_hs) state_d = S_RESP;
            S_WR_REQ:  if (aw_all && w_all) state_d = S_WR_RESP;
            S_WR_RESP: if (b_hs) state_d = S_RESP;
            S_RESP:    if (resp_hs) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state, so an async reset into IDLE
    // drops every valid/ready immediately. req_ready is also gated by rst
    // because IDLE is the reset state.
    always_comb begin
        req_ready  = rst && (state_q == S_IDLE);
        arvalid    = (state_q == S_RD_ADDR);
        rready     = (state_q == S_RD_DATA);
        awvalid    = (state_q == S_WR_REQ) && !aw_done_q;
        wvalid     = (state_q == S_WR_REQ) && !w_done_q;
        bready     = (state_q == S_WR_RESP);
        resp_valid = (state_q == S_RESP);
        araddr     = addr_q;
        awaddr     = addr_q;
        wdata      = wdata_q;
        wstrb      = wstrb_q;
        resp_rdata = rsp_data_q;
        resp_code  = rsp_code_q;
        resp_lat   = rsp_lat_q;
    end

    // Datapath next-state: request latch, done flags, latency counter and
    // response capture.
    always_comb begin
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_code_d = rsp_code_q;
        rsp_lat_d  = rsp_lat_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_RD_ADDR: cnt_d = sat_inc(cnt_q);
            S_RD_DATA: begin
                cnt_d = sat_inc(cnt_q);
                if (r_hs) begin
                    rsp_data_d = rdata;
                    rsp_code_d = rresp;
                    // The capture edge itself is counted in the latency.
                    rsp_lat_d  = sat_inc(cnt_q);
                end
            end
            S_WR_REQ: begin
                cnt_d     = sat_inc(cnt_q);
                aw_done_d = aw_all;
                w_done_d  = w_all;
            end
            S_WR_RESP: begin
                cnt_d = sat_inc(cnt_q);
                if (b_hs) begin
                    rsp_data_d = 32'h0;
                    rsp_code_d = bresp;
                    rsp_lat_d  = sat_inc(cnt_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            cnt_q      <= '0;
            rsp_data_q <= 32'h0;
            rsp_code_q <= 2'b00;
            rsp_lat_q  <= '0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_code_q <= rsp_code_d;
            rsp_lat_q  <= rsp_lat_d;
        end
    end

endmodule
